// File: rtl/sp_seq_pkg.sv
// Shared definitions for the ShortestPath_4 run sequencer.
//   - seq_state_e : sequencer FSM states
//   - default B-port address/data widths and the default RUN timeout
//   - CNT_WIDTH   : width of the run-cycle counter and Run_Cycles
package sp_seq_pkg;

  localparam int A_INIT_WIDTH_DEF   = 11;
  localparam int D_INIT_WIDTH_DEF   = 32;
  localparam int TIMEOUT_CYCLES_DEF = 1048576;
  localparam int CNT_WIDTH          = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CORE_RST,
    ST_GO,
    ST_RUN,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_PRESENT,
    ST_FIN,
    ST_ERR
  } seq_state_e;

endpackage

// File: rtl/sp_run_sequencer_counter.sv
// Saturating cycle counter used for RUN timing and the RUN timeout.
// Ports:
//   Clk, Rst     : clock, asynchronous active-low reset
//   clear        : load zero (wins over enable)
//   enable       : advance by one (sticks at all-ones)
//   count_inc    : saturated count + 1, i.e. the value after this cycle
//   terminal_hit : count_inc equals TERMINAL
module sp_cycle_counter
  import sp_seq_pkg::*;
#(
  parameter logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(1)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count_inc,
  output logic                 terminal_hit
);

  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;

  always_comb begin
    count_inc    = (count_reg == '1) ? count_reg : count_reg + CNT_WIDTH'(1);
    terminal_hit = (count_inc == TERMINAL);
    count_next   = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_inc;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/sp_run_sequencer.sv
// Runs one ShortestPath_4 job through the SRAM B ports:
// stream image into M, pulse Core_Rst then Go, wait for Done (with
// timeout), then stream P back out one word at a time.
// Ports:
//   Clk, Rst                   : clock, asynchronous active-low reset
//   Start, Abort               : job control (Abort wins over everything)
//   Load_Data/Valid/Ready      : input word stream -> M SRAM B port
//   M_Addr_B/Din_B/En_B/We_B   : M SRAM B port
//   Core_Rst, Go, Done         : core control
//   P_Addr_B/Dout_B/En_B/We_B  : P SRAM B port (1-cycle read latency)
//   Dump_Data/Valid/Ready      : result word stream
//   Busy, Finished, Timeout_Err, Run_Cycles : status
module sp_run_sequencer
  import sp_seq_pkg::*;
#(
  parameter int          A_INIT_WIDTH   = A_INIT_WIDTH_DEF,
  parameter int          D_INIT_WIDTH   = D_INIT_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic                    Abort,
  input  logic [D_INIT_WIDTH-1:0] Load_Data,
  input  logic                    Load_Valid,
  output logic                    Load_Ready,
  output logic [A_INIT_WIDTH-1:0] M_Addr_B,
  output logic [D_INIT_WIDTH-1:0] M_Din_B,
  output logic                    M_En_B,
  output logic                    M_We_B,
  output logic                    Core_Rst,
  output logic                    Go,
  input  logic                    Done,
  output logic [A_INIT_WIDTH-1:0] P_Addr_B,
  input  logic [D_INIT_WIDTH-1:0] P_Dout_B,
  output logic                    P_En_B,
  output logic                    P_We_B,
  output logic [D_INIT_WIDTH-1:0] Dump_Data,
  output logic                    Dump_Valid,
  input  logic                    Dump_Ready,
  output logic                    Busy,
  output logic                    Finished,
  output logic                    Timeout_Err,
  output logic [CNT_WIDTH-1:0]    Run_Cycles
);

  // One spare bit so the address never wraps arithmetically and the
  // last-word compare is exact.
  localparam int AW1 = A_INIT_WIDTH + 1;
  localparam logic [AW1-1:0] LAST_ADDR = AW1'((1 << A_INIT_WIDTH) - 1);

  seq_state_e             state_reg, state_next;
  logic [AW1-1:0]          addr_reg, addr_next;
  logic [CNT_WIDTH-1:0]    run_cycles_reg, run_cycles_next;
  logic [D_INIT_WIDTH-1:0] dump_data_reg, dump_data_next;
  logic                    m_write;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    cnt_terminal;

  // Cleared in GO so the first RUN cycle sees count 0; Run_Cycles then
  // equals the number of cycles from Go to Done inclusive of Done.
  sp_cycle_counter #(
    .TERMINAL (CNT_WIDTH'(TIMEOUT_CYCLES))
  ) u_run_counter (
    .Clk          (Clk),
    .Rst          (Rst),
    .clear        (state_reg == ST_GO),
    .enable       (state_reg == ST_RUN),
    .count_inc    (cnt_inc),
    .terminal_hit (cnt_terminal)
  );

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    run_cycles_next = run_cycles_reg;
    dump_data_next  = dump_data_reg;
    m_write         = 1'b0;
    Load_Ready      = 1'b0;
    Core_Rst        = 1'b0;
    Go              = 1'b0;
    P_En_B          = 1'b0;
    Dump_Valid      = 1'b0;

    // Abort suppresses every strobe of the current cycle as well, so an
    // aborted cycle never half-completes a handshake.
    if (Abort) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_IDLE, ST_FIN, ST_ERR: begin
          if (Start) begin
            state_next      = ST_LOAD;
            addr_next       = '0;
            run_cycles_next = '0;
          end
        end
        ST_LOAD: begin
          Load_Ready = 1'b1;
          if (Load_Valid) begin
            m_write   = 1'b1;
            addr_next = addr_reg + AW1'(1);
            if (addr_reg == LAST_ADDR) begin
              state_next = ST_CORE_RST;
            end
          end
        end
        ST_CORE_RST: begin
          Core_Rst   = 1'b1;
          state_next = ST_GO;
        end
        ST_GO: begin
          Go         = 1'b1;
          state_next = ST_RUN;
        end
        ST_RUN: begin
          // Done beats the timeout when both land in the same cycle.
          if (Done) begin
            run_cycles_next = cnt_inc;
            addr_next       = '0;
            state_next      = ST_RD_ISSUE;
          end else if (cnt_terminal) begin
            state_next = ST_ERR;
          end
        end
        ST_RD_ISSUE: begin
          P_En_B     = 1'b1;
          state_next = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          dump_data_next = P_Dout_B;
          state_next     = ST_PRESENT;
        end
        ST_PRESENT: begin
          Dump_Valid = 1'b1;
          if (Dump_Ready) begin
            if (addr_reg == LAST_ADDR) begin
              state_next = ST_FIN;
            end else begin
              addr_next  = addr_reg + AW1'(1);
              state_next = ST_RD_ISSUE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      run_cycles_reg <= '0;
      dump_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      run_cycles_reg <= run_cycles_next;
      dump_data_reg  <= dump_data_next;
    end
  end

  assign M_En_B      = m_write;
  assign M_We_B      = m_write;
  assign M_Din_B     = m_write ? Load_Data : '0;
  assign M_Addr_B    = addr_reg[A_INIT_WIDTH-1:0];
  assign P_Addr_B    = addr_reg[A_INIT_WIDTH-1:0];
  assign P_We_B      = 1'b0;
  assign Dump_Data   = dump_data_reg;
  assign Run_Cycles  = run_cycles_reg;
  assign Finished    = (state_reg == ST_FIN);
  assign Timeout_Err = (state_reg == ST_ERR);
  assign Busy        = (state_reg != ST_IDLE) && (state_reg != ST_FIN) &&
                       (state_reg != ST_ERR);

endmodule

// File: tb/tb_sp_run_sequencer.sv
module tb_sp_run_sequencer;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int WORDS = 16;
  localparam int TMO   = 100;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic [DW-1:0] Load_Data = '0;
  logic          Load_Valid = 1'b0;
  logic          Load_Ready;
  logic [AW-1:0] M_Addr_B;
  logic [DW-1:0] M_Din_B;
  logic          M_En_B;
  logic          M_We_B;
  logic          Core_Rst;
  logic          Go;
  logic          Done = 1'b0;
  logic [AW-1:0] P_Addr_B;
  logic [DW-1:0] P_Dout_B;
  logic          P_En_B;
  logic          P_We_B;
  logic [DW-1:0] Dump_Data;
  logic          Dump_Valid;
  logic          Dump_Ready = 1'b0;
  logic          Busy;
  logic          Finished;
  logic          Timeout_Err;
  logic [31:0]   Run_Cycles;

  sp_run_sequencer #(
    .A_INIT_WIDTH   (AW),
    .D_INIT_WIDTH   (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .Abort       (Abort),
    .Load_Data   (Load_Data),
    .Load_Valid  (Load_Valid),
    .Load_Ready  (Load_Ready),
    .M_Addr_B    (M_Addr_B),
    .M_Din_B     (M_Din_B),
    .M_En_B      (M_En_B),
    .M_We_B      (M_We_B),
    .Core_Rst    (Core_Rst),
    .Go          (Go),
    .Done        (Done),
    .P_Addr_B    (P_Addr_B),
    .P_Dout_B    (P_Dout_B),
    .P_En_B      (P_En_B),
    .P_We_B      (P_We_B),
    .Dump_Data   (Dump_Data),
    .Dump_Valid  (Dump_Valid),
    .Dump_Ready  (Dump_Ready),
    .Busy        (Busy),
    .Finished    (Finished),
    .Timeout_Err (Timeout_Err),
    .Run_Cycles  (Run_Cycles)
  );

  always #5 Clk = ~Clk;

  // P SRAM model, 1-cycle read latency, preloaded with 0xA0+i.
  logic [DW-1:0] p_mem [WORDS];
  logic [DW-1:0] p_dout_reg = '0;
  always @(posedge Clk) if (P_En_B) p_dout_reg <= p_mem[P_Addr_B];
  assign P_Dout_B = p_dout_reg;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mw_t;

  mw_t           m_q [$];
  logic [DW-1:0] d_q [$];
  mw_t           m_exp;
  int            n_checks = 0;
  int            n_pass = 0;
  int            m_write_cnt = 0;
  int            dump_valid_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard side: M writes and Dump handshakes are popped and compared.
  always @(negedge Clk) begin
    if (M_En_B) begin
      m_write_cnt <= m_write_cnt + 1;
      check("m_write_expected", 64'(m_q.size() != 0), 64'd1);
      if (m_q.size() != 0) begin
        m_exp = m_q.pop_front();
        check("m_addr", 64'(M_Addr_B), 64'(m_exp.addr));
        check("m_data", 64'(M_Din_B), 64'(m_exp.data));
        check("m_we", 64'(M_We_B), 64'd1);
      end
    end
    if (Dump_Valid) dump_valid_cnt <= dump_valid_cnt + 1;
    if (Dump_Valid && Dump_Ready) begin
      check("dump_expected", 64'(d_q.size() != 0), 64'd1);
      if (d_q.size() != 0) check("dump_data", 64'(Dump_Data), 64'(d_q.pop_front()));
    end
  end

  task automatic start_job();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("load_entry_ready", 64'(Load_Ready), 64'd1);
    check("load_entry_flags", 64'({Finished, Timeout_Err}), 64'd0);
    check("load_entry_run_cycles", 64'(Run_Cycles), 64'd0);
  endtask

  task automatic load_words(input logic [DW-1:0] base, input int count, input bit gap,
                            output int ticks);
    int  n;
    mw_t e;
    ticks = 0;
    for (int i = 0; i < count; i++) begin
      if (gap && i > 0) begin
        Load_Valid = 1'b0;
        Load_Data  = 32'hDEAD_0000 + 32'(i);
        tick();
        ticks++;
      end
      Load_Valid = 1'b1;
      Load_Data  = base + 32'(i);
      e.addr = AW'(i);
      e.data = base + 32'(i);
      m_q.push_back(e);
      n = 0;
      while (!Load_Ready && n < 10) begin
        tick();
        ticks++;
        n++;
      end
      check("load_ready_wait", 64'(Load_Ready), 64'd1);
      tick();
      ticks++;
    end
    Load_Valid = 1'b0;
    Load_Data  = '0;
  endtask

  // Entered in CORE_RST; returns in the Go cycle.
  task automatic go_phase();
    check("core_rst_pulse", 64'(Core_Rst), 64'd1);
    check("load_ready_drop", 64'(Load_Ready), 64'd0);
    check("go_before", 64'(Go), 64'd0);
    tick();
    check("go_pulse", 64'(Go), 64'd1);
    check("core_rst_single", 64'(Core_Rst), 64'd0);
  endtask

  // From the Go cycle: Done arrives n cycles after Go.
  task automatic run_to_done(input int n);
    tick();
    check("go_single", 64'(Go), 64'd0);
    check("busy_run", 64'(Busy), 64'd1);
    repeat (n - 1) tick();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("run_cycles", 64'(Run_Cycles), 64'(n));
    check("rd_issue_en", 64'({P_En_B, P_We_B}), 64'b10);
  endtask

  task automatic dump_words(input int stall_word);
    int n;
    for (int w = 0; w < WORDS; w++) begin
      d_q.push_back(32'hA0 + 32'(w));
      Dump_Ready = 1'b0;
      n = 0;
      while (!Dump_Valid && n < 10) begin
        tick();
        n++;
      end
      check("dump_valid_wait", 64'(Dump_Valid), 64'd1);
      if (w == stall_word) begin
        repeat (5) begin
          check("stall_data_hold", 64'(Dump_Data), 64'(32'hA0 + 32'(w)));
          check("stall_valid_hold", 64'(Dump_Valid), 64'd1);
          tick();
        end
      end
      Dump_Ready = 1'b1;
      tick();
    end
    Dump_Ready = 1'b0;
    check("finished", 64'(Finished), 64'd1);
  endtask

  initial begin
    int ticks;
    int mw0;
    int dv0;
    int n;

    for (int i = 0; i < WORDS; i++) p_mem[i] = 32'hA0 + 32'(i);

    // Reset state.
    #1;
    check("reset_strobes", 64'({Busy, Load_Ready, M_En_B, M_We_B, Go, Core_Rst, P_En_B,
                                Dump_Valid, Finished, Timeout_Err, M_Addr_B, P_Addr_B}), 64'd0);
    check("reset_run_cycles", 64'(Run_Cycles), 64'd0);
    check("reset_dump_data", 64'(Dump_Data), 64'd0);
    repeat (3) @(posedge Clk);
    #3 Rst = 1'b1;
    tick();
    // Done outside RUN is ignored.
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("done_idle_ignored", 64'({Busy, Run_Cycles}), 64'd0);

    // Job 1: continuous load, Done 37 cycles after Go, free-running dump.
    start_job();
    mw0 = m_write_cnt;
    load_words(32'h1000, WORDS, 1'b0, ticks);
    check("load_consecutive", 64'(ticks), 64'(WORDS));
    check("load_count", 64'(m_write_cnt - mw0), 64'(WORDS));
    go_phase();
    run_to_done(37);
    for (int w = 0; w < WORDS; w++) d_q.push_back(32'hA0 + 32'(w));
    Dump_Ready = 1'b1;
    n = 0;
    while (!Finished && n < 200) begin
      tick();
      n++;
    end
    Dump_Ready = 1'b0;
    check("dump_3_cycles_per_word", 64'(n), 64'(3 * WORDS));
    check("job1_finished", 64'({Finished, Busy}), 64'b10);
    check("job1_queues_empty", 64'(m_q.size() + d_q.size()), 64'd0);

    // Job 2: Load_Valid every other cycle, dump stalled on word 3.
    start_job();
    mw0 = m_write_cnt;
    load_words(32'h2000, WORDS, 1'b1, ticks);
    check("gap_load_count", 64'(m_write_cnt - mw0), 64'(WORDS));
    go_phase();
    run_to_done(5);
    dump_words(3);
    check("job2_queues_empty", 64'(m_q.size() + d_q.size()), 64'd0);

    // Job 3: no Done. Timeout is decided in the RUN cycle TMO after Go,
    // so Timeout_Err first shows TMO+1 cycles after the Go cycle.
    start_job();
    load_words(32'h3000, WORDS, 1'b0, ticks);
    go_phase();
    dv0 = dump_valid_cnt;
    n = 0;
    while (!Timeout_Err && n < 300) begin
      tick();
      n++;
    end
    check("timeout_latency", 64'(n), 64'(TMO + 1));
    check("timeout_flags", 64'({Timeout_Err, Busy, Finished}), 64'b100);
    check("timeout_no_dump", 64'(dump_valid_cnt - dv0), 64'd0);
    check("timeout_run_cycles", 64'(Run_Cycles), 64'd0);

    // Restart from ERR at address 0, then abort at load word 7.
    start_job();
    load_words(32'h4000, 7, 1'b0, ticks);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_load_state", 64'({Busy, Load_Ready, M_En_B, M_We_B}), 64'd0);
    Load_Valid = 1'b1;
    Load_Data  = 32'h4007;
    #2;
    check("idle_no_write", 64'({M_En_B, Load_Ready}), 64'd0);
    tick();
    Load_Valid = 1'b0;
    Load_Data  = '0;
    check("abort_queue_empty", 64'(m_q.size()), 64'd0);

    // Abort together with Start stays in IDLE.
    Start = 1'b1;
    Abort = 1'b1;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    check("abort_start_idle", 64'({Busy, Load_Ready}), 64'd0);
    tick();
    check("abort_start_stays", 64'(Busy), 64'd0);

    // Job 4: abort while word 0 is presented.
    start_job();
    load_words(32'h5000, WORDS, 1'b0, ticks);
    go_phase();
    run_to_done(3);
    n = 0;
    while (!Dump_Valid && n < 10) begin
      tick();
      n++;
    end
    check("present_word0", 64'(Dump_Data), 64'hA0);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_present_state", 64'({Busy, Dump_Valid, P_En_B, Finished}), 64'd0);
    check("abort_run_cycles_held", 64'(Run_Cycles), 64'd3);

    // Job 5: asynchronous reset mid-RUN, late Done ignored.
    start_job();
    load_words(32'h6000, WORDS, 1'b0, ticks);
    go_phase();
    repeat (10) tick();
    #2 Rst = 1'b0;
    #1;
    check("async_reset_strobes", 64'({Busy, Load_Ready, M_En_B, Go, Core_Rst, P_En_B,
                                      Dump_Valid, Finished, Timeout_Err, M_Addr_B}), 64'd0);
    check("async_reset_dump_data", 64'(Dump_Data), 64'd0);
    @(posedge Clk);
    #1 Rst = 1'b1;
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("late_done_ignored", 64'({Busy, Run_Cycles}), 64'd0);
    tick();
    check("idle_after_reset", 64'({Busy, Finished, Timeout_Err}), 64'd0);
    check("final_queues_empty", 64'(m_q.size() + d_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
